// File: rtl/packet_checker.sv
// Purpose: verify a 32-bit LFSR packet stream, self-syncing from received data; keep statistics.
// Latency: locked, the pulses and the counters update on the clock edge after the slot; pulses last one cycle.
// Backpressure: none; one word per data_valid cycle is always accepted.
module packet_checker #(
  parameter int PACKET_WORDS = 32,
  parameter int CNT_W        = 16,
  parameter int LOSS_THRESH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      data_in,
  input  logic             data_valid,
  input  logic             packet_done,
  input  logic             clear_stats,
  output logic             locked,
  output logic             pkt_ok,
  output logic             pkt_err,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] word_err_count,
  output logic [CNT_W-1:0] len_err_count
);

  localparam int WC_W = $clog2(PACKET_WORDS) + 1;
  localparam int MR_W = $clog2(LOSS_THRESH + 1);
  localparam logic [WC_W-1:0] LEN_GOOD = WC_W'(PACKET_WORDS - 1);
  localparam logic [MR_W-1:0] MR_THRESH = MR_W'(LOSS_THRESH);

  typedef enum logic [1:0] {HUNT, SYNC, CHECK} state_t;

  state_t            state_q, state_d;
  logic [31:0]       exp_lfsr_q, exp_lfsr_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [MR_W-1:0]   miss_run_q, miss_run_d;
  logic              pkt_bad_q, pkt_bad_d;
  logic              locked_q, locked_d;
  logic              pkt_ok_q, pkt_ok_d;
  logic              pkt_err_q, pkt_err_d;
  logic [CNT_W-1:0]  pkt_count_q, pkt_count_d;
  logic [CNT_W-1:0]  word_err_q, word_err_d;
  logic [CNT_W-1:0]  len_err_q, len_err_d;
  logic              mismatch;
  logic              len_bad;
  logic              lost;

  // Same polynomial as the generator: x^32+x^22+x^2+x+1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Next-state, word/length checking and statistics.
  always_comb begin
    state_d     = state_q;
    exp_lfsr_d  = exp_lfsr_q;
    word_cnt_d  = word_cnt_q;
    miss_run_d  = miss_run_q;
    pkt_bad_d   = pkt_bad_q;
    locked_d    = locked_q;
    pkt_ok_d    = 1'b0;
    pkt_err_d   = 1'b0;
    pkt_count_d = pkt_count_q;
    word_err_d  = word_err_q;
    len_err_d   = len_err_q;
    mismatch    = 1'b0;
    len_bad     = 1'b0;
    lost        = 1'b0;

    case (state_q)
      HUNT: begin
        // A packet end marks the boundary; the next word seeds the local LFSR.
        if (packet_done) state_d = SYNC;
      end
      SYNC: begin
        if (data_valid) begin
          exp_lfsr_d = lfsr_next(data_in);
          word_cnt_d = WC_W'(1);
          pkt_bad_d  = 1'b0;
          miss_run_d = '0;
          locked_d   = 1'b1;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        // Transmitter steps once per slot, even when a word and the end share a cycle.
        if (data_valid || packet_done) exp_lfsr_d = lfsr_next(exp_lfsr_q);
        if (data_valid) begin
          word_cnt_d = (&word_cnt_q) ? word_cnt_q : word_cnt_q + WC_W'(1);
          if (data_in != exp_lfsr_q) begin
            mismatch   = 1'b1;
            word_err_d = sat_inc(word_err_q);
            pkt_bad_d  = 1'b1;
            miss_run_d = miss_run_q + MR_W'(1);
            lost       = (miss_run_d == MR_THRESH);
          end else begin
            miss_run_d = '0;
          end
        end
        if (lost) begin
          // The packet in flight is abandoned without a count or pulse.
          state_d    = HUNT;
          locked_d   = 1'b0;
          word_cnt_d = '0;
          pkt_bad_d  = 1'b0;
          miss_run_d = '0;
        end else if (packet_done) begin
          len_bad     = (word_cnt_d != LEN_GOOD);
          pkt_count_d = sat_inc(pkt_count_q);
          if (len_bad) len_err_d = sat_inc(len_err_q);
          if (pkt_bad_d || len_bad) pkt_err_d = 1'b1;
          else                      pkt_ok_d  = 1'b1;
          word_cnt_d = '0;
          pkt_bad_d  = 1'b0;
        end
      end
      default: state_d = HUNT;
    endcase

    if (clear_stats) begin
      pkt_count_d = '0;
      word_err_d  = '0;
      len_err_d   = '0;
    end
  end

  // State and statistics registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      exp_lfsr_q  <= '0;
      word_cnt_q  <= '0;
      miss_run_q  <= '0;
      pkt_bad_q   <= 1'b0;
      locked_q    <= 1'b0;
      pkt_ok_q    <= 1'b0;
      pkt_err_q   <= 1'b0;
      pkt_count_q <= '0;
      word_err_q  <= '0;
      len_err_q   <= '0;
    end else begin
      state_q     <= state_d;
      exp_lfsr_q  <= exp_lfsr_d;
      word_cnt_q  <= word_cnt_d;
      miss_run_q  <= miss_run_d;
      pkt_bad_q   <= pkt_bad_d;
      locked_q    <= locked_d;
      pkt_ok_q    <= pkt_ok_d;
      pkt_err_q   <= pkt_err_d;
      pkt_count_q <= pkt_count_d;
      word_err_q  <= word_err_d;
      len_err_q   <= len_err_d;
    end
  end

  assign locked         = locked_q;
  assign pkt_ok         = pkt_ok_q;
  assign pkt_err        = pkt_err_q;
  assign pkt_count      = pkt_count_q;
  assign word_err_count = word_err_q;
  assign len_err_count  = len_err_q;

endmodule
